// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// memory and holds the IF/ID register that feeds decoderStage.
module fetch_stage #(
  parameter int unsigned                  PC_WIDTH    = 8,
  parameter int unsigned                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]          RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0]       NOP_INSTR   = 16'hB000,
  parameter logic [3:0]                   HALT_OPCODE = 4'hE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic [2:0]             branchEn,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  input  logic                   flagZ,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [PC_WIDTH-1:0]    pcOut,
  output logic                   instrValid,
  output logic                   flush,
  output logic                   halted
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pcNext;
  logic                memValid;
  logic                haltedR;
  logic                taken;
  logic                isHalt;

  always_comb begin
    taken  = branchEn[2] | (branchEn[1] & flagZ) | (branchEn[0] & ~flagZ);
    isHalt = (imemData[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
    if (taken)
      pcNext = branchTarget;
    else if (!memValid || stall || haltedR)
      pcNext = pc;  // re-read the same word so imemData stays aligned with pc
    else
      pcNext = pc + PC_WIDTH'(1);
  end

  assign imemAddr = rst ? pcNext : RESET_PC;
  assign flush    = taken;
  assign halted   = haltedR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      memValid    <= 1'b0;
      haltedR     <= 1'b0;
      instruction <= NOP_INSTR;
      pcOut       <= '0;
      instrValid  <= 1'b0;
    end else begin
      pc       <= pcNext;
      memValid <= 1'b1;
      if (taken) begin
        // any HALT seen so far is younger than the branch, so it is squashed
        instruction <= NOP_INSTR;
        instrValid  <= 1'b0;
        haltedR     <= 1'b0;
      end else if (stall) begin
        instruction <= instruction;
        pcOut       <= pcOut;
        instrValid  <= instrValid;
      end else if (haltedR || !memValid) begin
        instruction <= NOP_INSTR;
        instrValid  <= 1'b0;
      end else begin
        instruction <= imemData;
        pcOut       <= pc;
        instrValid  <= 1'b1;
        if (isHalt)
          haltedR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a synchronous instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  branchEn;
  logic [7:0]  branchTarget;
  logic        flagZ;
  logic [7:0]  imemAddr;
  logic [15:0] imemData;
  logic [15:0] instruction;
  logic [7:0]  pcOut;
  logic        instrValid;
  logic        flush;
  logic        halted;

  logic [15:0] mem [256];
  int unsigned total = 0;
  int unsigned bad   = 0;

  fetch_stage #(
    .PC_WIDTH(8),
    .INSTR_WIDTH(16),
    .RESET_PC(8'h00),
    .NOP_INSTR(16'hB000),
    .HALT_OPCODE(4'hE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .branchEn(branchEn),
    .branchTarget(branchTarget),
    .flagZ(flagZ),
    .imemAddr(imemAddr),
    .imemData(imemData),
    .instruction(instruction),
    .pcOut(pcOut),
    .instrValid(instrValid),
    .flush(flush),
    .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imemData <= mem[imemAddr];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expIf(input string tag, input logic [15:0] ins, input logic [7:0] pco,
                       input logic vld);
    checkEq({tag, ".instr"}, 32'(instruction), 32'(ins));
    checkEq({tag, ".pcOut"}, 32'(pcOut), 32'(pco));
    checkEq({tag, ".valid"}, 32'(instrValid), 32'(vld));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[0] = 16'hF510; mem[1] = 16'h0612; mem[2] = 16'h3260; mem[3] = 16'h2190;
    mem[4] = 16'hE000;

    rst = 1'b0; stall = 1'b0; branchEn = 3'b000; branchTarget = 8'h00; flagZ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expIf("reset", 16'hB000, 8'h00, 1'b0);
    checkEq("reset.halted", 32'(halted), 32'h0);
    checkEq("reset.imemAddr", 32'(imemAddr), 32'h00);
    rst = 1'b1;

    // startup latency and sequential stream
    tick(); checkEq("edge1.valid", 32'(instrValid), 32'h0);
    tick(); expIf("edge2", 16'hF510, 8'h00, 1'b1);
    tick(); expIf("edge3", 16'h0612, 8'h01, 1'b1);
    tick(); expIf("edge4", 16'h3260, 8'h02, 1'b1);

    // stall three cycles holding pcOut=2
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expIf("stall", 16'h3260, 8'h02, 1'b1);
    end
    stall = 1'b0;
    tick(); expIf("unstall", 16'h2190, 8'h03, 1'b1);

    // HALT captured, then held with bubbles
    tick(); expIf("haltCap", 16'hE000, 8'h04, 1'b1);
    checkEq("haltCap.halted", 32'(halted), 32'h1);
    checkEq("haltCap.imemAddr", 32'(imemAddr), 32'h05);
    for (int i = 0; i < 2; i++) begin
      tick(); expIf("haltHold", 16'hB000, 8'h04, 1'b0);
      checkEq("haltHold.halted", 32'(halted), 32'h1);
      checkEq("haltHold.imemAddr", 32'(imemAddr), 32'h05);
    end

    // jmp to 0xFF clears halt, then wrap to 0x00
    branchEn = 3'b100; branchTarget = 8'hFF; #1;
    checkEq("jmpFF.flush", 32'(flush), 32'h1);
    checkEq("jmpFF.imemAddr", 32'(imemAddr), 32'hFF);
    tick(); branchEn = 3'b000;
    expIf("jmpFF.bubble", 16'hB000, 8'h04, 1'b0);
    checkEq("jmpFF.halted", 32'(halted), 32'h0);
    tick(); expIf("wrapFF", 16'h10FF, 8'hFF, 1'b1);
    tick(); expIf("wrap00", 16'hF510, 8'h00, 1'b1);
    tick(); expIf("wrap01", 16'h0612, 8'h01, 1'b1);

    // unconditional jump to 0x15
    branchEn = 3'b100; branchTarget = 8'h15; #1;
    checkEq("jmp15.flush", 32'(flush), 32'h1);
    tick(); branchEn = 3'b000;
    expIf("jmp15.bubble", 16'hB000, 8'h01, 1'b0);
    tick(); expIf("jmp15.target", 16'h1015, 8'h15, 1'b1);
    tick(); expIf("jmp15.next", 16'h1016, 8'h16, 1'b1);

    // je with Z=0: not taken
    branchEn = 3'b010; branchTarget = 8'h50; flagZ = 1'b0; #1;
    checkEq("je.flush", 32'(flush), 32'h0);
    tick(); branchEn = 3'b000;
    expIf("je.seq", 16'h1017, 8'h17, 1'b1);

    // jne with Z=0: taken to 0x32
    branchEn = 3'b001; branchTarget = 8'h32; #1;
    checkEq("jne.flush", 32'(flush), 32'h1);
    tick(); branchEn = 3'b000;
    expIf("jne.bubble", 16'hB000, 8'h17, 1'b0);
    tick(); expIf("jne.target", 16'h1032, 8'h32, 1'b1);

    // stall and jmp together: branch wins
    stall = 1'b1; branchEn = 3'b100; branchTarget = 8'h40; #1;
    checkEq("stallJmp.flush", 32'(flush), 32'h1);
    tick(); stall = 1'b0; branchEn = 3'b000;
    expIf("stallJmp.bubble", 16'hB000, 8'h32, 1'b0);
    tick(); expIf("stallJmp.target", 16'h1040, 8'h40, 1'b1);
    tick(); expIf("stallJmp.next", 16'h1041, 8'h41, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of decoderStage.
- Owns the program counter and drives the synchronous instruction memory.
- Holds the IF/ID register whose instruction output feeds decoderStage.
- Applies jmp/je/jne redirects resolved downstream, squashes wrong-path instructions, supports pipeline stall, and halts on a HALT opcode.

Parameters:
PC_WIDTH, 8, PC/address width; matches the 8-bit Immediate branch target.
INSTR_WIDTH, 16, instruction width.
RESET_PC, 0, PC value after reset.
NOP_INSTR, 16'hB000, bubble instruction (opcode B is unused and decodes to no writes).
HALT_OPCODE, 4'hE, instruction[15:12] value that stops fetch.

Ports:
clk  in  1  clock, single clock domain.
rst  in  1  asynchronous, active-low reset.
stall  in  1  hold IF/ID and PC (hazard from downstream).
branchEn  in  3  PcWriteEn from the branch-resolving stage: [2]=jmp, [1]=je, [0]=jne.
branchTarget  in  PC_WIDTH  branch target (Immediate of the resolving instruction).
flagZ  in  1  current zero flag (Nz register).
imemAddr  out  PC_WIDTH  instruction memory read address; memory registers it and returns data one cycle later.
imemData  in  INSTR_WIDTH  memory read data, aligned with pc.
instruction  out  INSTR_WIDTH  IF/ID instruction to decoderStage.
pcOut  out  PC_WIDTH  address of instruction.
instrValid  out  1  instruction is a real, non-squashed instruction.
flush  out  1  combinational; squash the instruction leaving IF/ID this cycle.
halted  out  1  fetch stopped by HALT.

Behaviour:
- State registers:
  - pc: address of the word on imemData.
  - memValid: imemData is meaningful.
  - haltedR.
  - IF/ID register: instruction, pcOut, instrValid.
- Reset (rst=0, async):
  - pc=RESET_PC, memValid=0, haltedR=0.
  - instruction=NOP_INSTR, pcOut=0, instrValid=0.
  - imemAddr=RESET_PC while in reset.
- Branch decode:
  - taken = branchEn[2] | (branchEn[1] & flagZ) | (branchEn[0] & ~flagZ).
  - Multiple bits set are OR'd.
  - flush = taken.
- Next-PC priority, combinational, drives imemAddr:
  1. taken -> branchTarget.
  2. !memValid | stall | haltedR -> pc (re-read the same word).
  3. Otherwise -> pc+1, modulo 2^PC_WIDTH (8'hFF wraps to 8'h00).
- At each clk edge: pc <= pcNext; memValid <= 1.
- IF/ID update priority:
  1. taken: instruction=NOP_INSTR, instrValid=0, pcOut unchanged, haltedR=0 (the HALT is younger and is squashed).
  2. stall: hold all IF/ID fields.
  3. haltedR | !memValid: instruction=NOP_INSTR, instrValid=0.
  4. Otherwise: instruction=imemData, pcOut=pc, instrValid=1. If imemData[15:12]==HALT_OPCODE, set haltedR=1 (the HALT itself is passed with instrValid=1).
- taken overrides stall in the same cycle.
- Latency:
  - First valid instruction appears in IF/ID 2 edges after reset release.
  - Sequential throughput is 1 instruction per cycle.
  - Taken branch costs exactly one bubble in IF/ID, plus the flush pulse to the next stage. The target instruction is in IF/ID on the second edge after the branch edge.
- Stall asserted for N cycles: IF/ID and pc are frozen for N edges; memory re-reads pc, so imemData stays aligned; no instruction is lost or duplicated.
- halted stays high until reset or a taken branch. While halted, pc is held and IF/ID emits NOP_INSTR.
- halted = haltedR.

Test Plan:
1. Reset with mem[0..3]={F510,0612,3260,2190}, release rst; no stall -> edge 2: instruction=F510, pcOut=0, instrValid=1; edges 3,4,5 give 0612, 3260, 2190 with pcOut 1,2,3.
2. Unconditional jump: branchEn=3'b100, branchTarget=8'h15 for one cycle -> flush=1 that cycle; next edge instruction=B000, instrValid=0; following edge instruction=mem[0x15], pcOut=0x15.
3. Conditional branches: branchEn=3'b010 with flagZ=0 -> not taken, sequential flow, flush=0. branchEn=3'b001 with flagZ=0, target 8'h32 -> taken, instruction=mem[0x32] after one bubble.
4. Stall 3 cycles while IF/ID holds pcOut=2 -> instruction/pcOut unchanged for 3 edges; after release next edge pcOut=3; no skipped or duplicated pcOut.
5. Stall and taken branch in the same cycle (target 8'h40) -> branch wins: bubble, then pcOut=0x40.
6. Halt and wrap:
   - mem[4]=E000 -> captured with instrValid=1, halted=1; afterwards NOP_INSTR with instrValid=0 and imemAddr fixed. A subsequent jmp to 8'hFF clears halted.
   - Sequential fetch from 0xFF then gives pcOut=0xFF followed by pcOut=0x00.
